// File: rtl/noise_channel_generator.sv
// LFSR noise voice: shift-clock divider, 15/7-bit LFSR, volume envelope and trigger restart.
// Define NOISE_LENGTH_COUNTER_EN to build the length counter that silences the channel.
module noise_channel_generator #(
   parameter int unsigned SAMPLE_WIDTH   = 20,
   parameter int unsigned HEADROOM_SHIFT = 3,
   parameter int unsigned CLK_SHIFT      = 0
) (
   input  logic                    I_BITCLK,
   input  logic                    I_RESET,
   input  logic                    I_STROBE,
   input  logic                    I_TRIGGER,
   input  logic [3:0]              I_SHIFT_CODE,
   input  logic [2:0]              I_DIV_CODE,
   input  logic                    I_BIT_WIDTH,
   input  logic [3:0]              I_ENV_INIT,
   input  logic                    I_ENV_DIR,
   input  logic [2:0]              I_ENV_PERIOD,
   input  logic                    I_ENV_TICK,
   input  logic                    I_LEN_EN,
   input  logic [5:0]              I_LEN_LOAD,
   input  logic                    I_LEN_TICK,
   input  logic                    I_WAVEFORM_EN,
   output logic [SAMPLE_WIDTH-1:0] O_SAMPLE,
   output logic                    O_ACTIVE,
   output logic [3:0]              O_VOLUME
);

   localparam int unsigned TIMER_W    = 20 + CLK_SHIFT;
   localparam int unsigned PER_W      = TIMER_W + 16;
   localparam int unsigned FULL_W     = SAMPLE_WIDTH + 4;
   localparam int unsigned FULL_SCALE = (32'd1 << (SAMPLE_WIDTH - 1)) - 32'd1;
   localparam int unsigned STEP       = FULL_SCALE / 15;

   logic [14:0]             r_lfsr;
   logic [TIMER_W-1:0]      r_timer;
   logic [3:0]              r_vol;
   logic [2:0]              r_env_cnt;
   logic                    r_active;
   logic [SAMPLE_WIDTH-1:0] r_sample;

   logic                    w_fb;
   logic [14:0]             w_lfsr_shift;
   logic [6:0]              w_base;
   logic [PER_W-1:0]        w_period_full;
   logic [TIMER_W-1:0]      w_period;
   logic [FULL_W-1:0]       w_mag_full;
   logic [SAMPLE_WIDTH-1:0] w_mag;
   logic                    w_env_fire;
   logic                    w_shift_ok;
   logic                    w_len_expire;

   // Next LFSR value; 7-bit mode also feeds the feedback bit into bit 6.
   always_comb begin
      w_fb         = r_lfsr[0] ^ r_lfsr[1];
      w_lfsr_shift = {w_fb, r_lfsr[14:1]};
      if (I_BIT_WIDTH) begin
         w_lfsr_shift[6] = w_fb;
      end
   end

   always_comb begin
      w_base        = (I_DIV_CODE == 3'd0) ? 7'd8 : {I_DIV_CODE, 4'b0000};
      w_period_full = (PER_W'(w_base) << I_SHIFT_CODE) << CLK_SHIFT;
      w_period      = w_period_full[TIMER_W-1:0];
      w_mag_full    = (FULL_W'(r_vol) * FULL_W'(STEP)) >> HEADROOM_SHIFT;
      w_mag         = w_mag_full[SAMPLE_WIDTH-1:0];
      w_env_fire    = r_active && I_ENV_TICK && (I_ENV_PERIOD != 3'd0);
      w_shift_ok    = (I_SHIFT_CODE < 4'd14);
   end

`ifdef NOISE_LENGTH_COUNTER_EN
   logic [6:0] r_len;

   always_ff @(posedge I_BITCLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_len <= 7'd0;
      end else if (I_TRIGGER) begin
         r_len <= 7'd64 - {1'b0, I_LEN_LOAD};
      end else if (I_LEN_TICK && I_LEN_EN && (r_len != 7'd0)) begin
         r_len <= r_len - 7'd1;
      end
   end

   assign w_len_expire = I_LEN_TICK && I_LEN_EN && (r_len == 7'd1);
`else
   logic w_unused_len;

   assign w_unused_len = ^{I_LEN_EN, I_LEN_LOAD, I_LEN_TICK};
   assign w_len_expire = 1'b0;
`endif

   // Channel state; a trigger overrides any tick or timer expiry in the same cycle.
   always_ff @(posedge I_BITCLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_lfsr    <= 15'h7FFF;
         r_timer   <= '0;
         r_vol     <= 4'd0;
         r_env_cnt <= 3'd0;
         r_active  <= 1'b0;
      end else if (I_TRIGGER) begin
         r_lfsr    <= 15'h7FFF;
         r_timer   <= w_period;
         r_vol     <= I_ENV_INIT;
         r_env_cnt <= I_ENV_PERIOD;
         r_active  <= !((I_ENV_INIT == 4'd0) && !I_ENV_DIR);
      end else begin
         if (r_active) begin
            if (r_timer == TIMER_W'(1)) begin
               r_timer <= w_period;
               if (w_shift_ok) begin
                  r_lfsr <= w_lfsr_shift;
               end
            end else begin
               r_timer <= r_timer - TIMER_W'(1);
            end
         end
         if (w_env_fire) begin
            if (r_env_cnt <= 3'd1) begin
               r_env_cnt <= I_ENV_PERIOD;
               if (I_ENV_DIR && (r_vol != 4'd15)) begin
                  r_vol <= r_vol + 4'd1;
               end else if (!I_ENV_DIR && (r_vol != 4'd0)) begin
                  r_vol <= r_vol - 4'd1;
               end
            end else begin
               r_env_cnt <= r_env_cnt - 3'd1;
            end
         end
         if (w_len_expire) begin
            r_active <= 1'b0;
         end
      end
   end

   // Sample register: disable clears at once, otherwise reload on the strobe.
   always_ff @(posedge I_BITCLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_sample <= '0;
      end else if (!I_WAVEFORM_EN || !r_active) begin
         r_sample <= '0;
      end else if (I_STROBE) begin
         r_sample <= r_lfsr[0] ? (-w_mag) : w_mag;
      end
   end

   assign O_SAMPLE = r_sample;
   assign O_ACTIVE = r_active;
   assign O_VOLUME = r_vol;

endmodule

// File: tb/tb_noise_channel_generator.sv
// Scoreboard bench for noise_channel_generator: behavioural model pushes expectations, monitor compares.
module tb_noise_channel_generator;

   typedef struct packed {
      logic [19:0] smp;
      logic        act;
      logic [3:0]  vol;
      logic [1:0]  dk;
      logic [19:0] dv;
   } exp_t;

   localparam int STEP = ((1 << 19) - 1) / 15;

   logic        clk, rst, strobe, trig, w, dir, etick, len_en, ltick, en;
   logic [3:0]  s, init;
   logic [2:0]  r, eper;
   logic [5:0]  len_load;
   logic [19:0] O_SAMPLE;
   logic        O_ACTIVE;
   logic [3:0]  O_VOLUME;

   exp_t q[$];
   exp_t m_e;
   int   total = 0;
   int   bad   = 0;
   int   m_lfsr, m_wait, m_vol, m_envc, m_len, m_act, m_smp;

   noise_channel_generator dut (
      .I_BITCLK(clk), .I_RESET(rst), .I_STROBE(strobe), .I_TRIGGER(trig),
      .I_SHIFT_CODE(s), .I_DIV_CODE(r), .I_BIT_WIDTH(w), .I_ENV_INIT(init),
      .I_ENV_DIR(dir), .I_ENV_PERIOD(eper), .I_ENV_TICK(etick), .I_LEN_EN(len_en),
      .I_LEN_LOAD(len_load), .I_LEN_TICK(ltick), .I_WAVEFORM_EN(en),
      .O_SAMPLE(O_SAMPLE), .O_ACTIVE(O_ACTIVE), .O_VOLUME(O_VOLUME)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lfsr_step(input int l, input logic w7);
      int x;
      x = (l ^ (l >> 1)) & 1;
      l = (l >> 1) | (x << 14);
      if (w7) l = (l & ~(1 << 6)) | (x << 6);
      return l;
   endfunction

   task automatic model_reset();
      m_lfsr = 32'h7FFF; m_wait = 0; m_vol = 0; m_envc = 0; m_len = 0; m_act = 0; m_smp = 0;
   endtask

   // One clock of the reference model, then the matching DUT edge.
   task automatic cyc(input int dk = 0, input logic [19:0] dv = 20'd0);
      exp_t e;
      int   p, mag;
      if (rst) begin
         model_reset();
      end else begin
         mag = (m_vol * STEP) >> 3;
         if (!en || m_act == 0) m_smp = 0;
         else if (strobe) m_smp = (m_lfsr & 1) ? ((-mag) & 32'hFFFFF) : mag;
         p = (((r == 3'd0) ? 8 : 16 * int'(r)) << int'(s)) & 32'hFFFFF;
         if (trig) begin
            m_lfsr = 32'h7FFF; m_wait = p; m_vol = int'(init); m_envc = int'(eper);
            m_len  = 64 - int'(len_load);
            m_act  = (init == 4'd0 && !dir) ? 0 : 1;
         end else begin
            if (m_act != 0) begin
               m_wait = m_wait - 1;
               if (m_wait == 0) begin
                  if (s < 4'd14) m_lfsr = lfsr_step(m_lfsr, w);
                  m_wait = p;
               end
            end
            if (m_act != 0 && etick && eper != 3'd0) begin
               m_envc = m_envc - 1;
               if (m_envc <= 0) begin
                  m_envc = int'(eper);
                  if (dir && m_vol < 15) m_vol = m_vol + 1;
                  else if (!dir && m_vol > 0) m_vol = m_vol - 1;
               end
            end
`ifdef NOISE_LENGTH_COUNTER_EN
            if (ltick && len_en && m_len > 0) begin
               m_len = m_len - 1;
               if (m_len == 0) m_act = 0;
            end
`endif
         end
      end
      e.smp = 20'(m_smp); e.act = (m_act != 0); e.vol = 4'(m_vol);
      e.dk  = 2'(dk);     e.dv  = dv;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      trig = 1'b0; etick = 1'b0; ltick = 1'b0;
   endtask

   // Monitor: pops on every clock edge; an asynchronous reset event checks outputs at once.
   always @(posedge clk or posedge rst) begin
      #1;
      if (clk) begin
         if (q.size() > 0) begin
            m_e = q.pop_front();
            total++;
            if (O_SAMPLE !== m_e.smp || O_ACTIVE !== m_e.act || O_VOLUME !== m_e.vol) begin
               bad++;
               $display("FAIL scoreboard t=%0t sample=%h want=%h active=%b want=%b volume=%0d want=%0d",
                        $time, O_SAMPLE, m_e.smp, O_ACTIVE, m_e.act, O_VOLUME, m_e.vol);
            end
            if (m_e.dk == 2'd1) begin
               total++;
               if (O_SAMPLE !== m_e.dv) begin
                  bad++;
                  $display("FAIL dir_sample t=%0t got=%h want=%h", $time, O_SAMPLE, m_e.dv);
               end
            end else if (m_e.dk == 2'd2) begin
               total++;
               if (O_ACTIVE !== m_e.dv[0]) begin
                  bad++;
                  $display("FAIL dir_active t=%0t got=%b want=%b", $time, O_ACTIVE, m_e.dv[0]);
               end
            end else if (m_e.dk == 2'd3) begin
               total++;
               if (O_VOLUME !== m_e.dv[3:0]) begin
                  bad++;
                  $display("FAIL dir_volume t=%0t got=%0d want=%0d", $time, O_VOLUME, m_e.dv[3:0]);
               end
            end
         end
      end else begin
         total++;
         if (O_SAMPLE !== 20'd0 || O_ACTIVE !== 1'b0 || O_VOLUME !== 4'd0) begin
            bad++;
            $display("FAIL async_reset t=%0t sample=%h active=%b volume=%0d want all 0",
                     $time, O_SAMPLE, O_ACTIVE, O_VOLUME);
         end
      end
   end

   initial begin
      rst = 1'b1; strobe = 1'b0; trig = 1'b0; w = 1'b0; dir = 1'b0; etick = 1'b0;
      len_en = 1'b0; ltick = 1'b0; en = 1'b1; s = 4'd0; init = 4'd15; r = 3'd0;
      eper = 3'd0; len_load = 6'd0;
      model_reset();
      @(negedge clk);
      repeat (3) cyc();
      rst = 1'b0;
      strobe = 1'b1;

      // 15-bit mode, P=8: high level after the 15th shift
      trig = 1'b1; cyc();
      for (int k = 1; k <= 130; k++) begin
         if (k == 120) cyc(1, 20'hF0001);
         else if (k == 121) cyc(1, 20'h0FFFF);
         else cyc();
      end

      // 7-bit mode: high level after the 7th shift
      w = 1'b1; trig = 1'b1; cyc();
      for (int k = 1; k <= 64; k++) begin
         if (k == 56) cyc(1, 20'hF0001);
         else if (k == 57) cyc(1, 20'h0FFFF);
         else cyc();
      end
      w = 1'b0;

      // Envelope decrease, increase and frozen
      eper = 3'd1; dir = 1'b0; init = 4'd15; trig = 1'b1; cyc();
      for (int k = 1; k <= 18; k++) begin
         etick = 1'b1;
         if (k == 14) cyc(3, 20'd1);
         else if (k == 15 || k == 18) cyc(3, 20'd0);
         else cyc();
      end
      dir = 1'b1; init = 4'd14; trig = 1'b1; cyc();
      for (int k = 1; k <= 3; k++) begin
         etick = 1'b1;
         cyc(3, 20'd15);
      end
      eper = 3'd0; init = 4'd7; trig = 1'b1; cyc();
      for (int k = 1; k <= 5; k++) begin
         etick = 1'b1;
         if (k == 5) cyc(3, 20'd7); else cyc();
      end

      // Length counter: load 62 gives two ticks
      init = 4'd15; dir = 1'b0; len_load = 6'd62; len_en = 1'b1; trig = 1'b1; cyc();
      ltick = 1'b1; cyc(2, 20'd1);
      cyc();
`ifdef NOISE_LENGTH_COUNTER_EN
      ltick = 1'b1; cyc(2, 20'd0);
      cyc(1, 20'd0);
`else
      ltick = 1'b1; cyc(2, 20'd1);
      cyc(2, 20'd1);
`endif
      len_en = 1'b0;

      // s=14 freezes the LFSR; DAC-off trigger deactivates
      s = 4'd14; trig = 1'b1; cyc();
      for (int k = 1; k <= 10000; k++) begin
         if (k == 10000) cyc(1, 20'hF0001); else cyc();
      end
      init = 4'd0; dir = 1'b0; trig = 1'b1; cyc(2, 20'd0);
      cyc(1, 20'd0);
      s = 4'd0;

      // Asynchronous reset mid-run, trigger beats envelope tick, disable clears sample
      r = 3'd1; init = 4'd12; trig = 1'b1; cyc();
      repeat (20) cyc();
      #2 rst = 1'b1;
      @(negedge clk);
      cyc();
      rst = 1'b0;
      eper = 3'd1; dir = 1'b0; init = 4'd9; trig = 1'b1; etick = 1'b1; cyc(3, 20'd9);
      repeat (5) cyc();
      en = 1'b0; cyc(1, 20'd0);
      en = 1'b1;

      // Randomised traffic against the model
      r = 3'(3'($urandom_range(7, 0))); s = 4'(4'($urandom_range(2, 0)));
      init = 4'd10; trig = 1'b1; cyc();
      for (int i = 0; i < 4000; i++) begin
         strobe = 1'($urandom_range(1, 0));
         trig   = ($urandom_range(299, 0) == 0);
         etick  = ($urandom_range(19, 0) == 0);
         ltick  = ($urandom_range(29, 0) == 0);
         if ($urandom_range(199, 0) == 0) en = ~en;
         if ($urandom_range(99, 0) == 0) begin
            r = 3'($urandom_range(7, 0));
            s = 4'($urandom_range(2, 0));
            w = 1'($urandom_range(1, 0));
         end
         if ($urandom_range(49, 0) == 0) begin
            init     = 4'($urandom_range(15, 0));
            dir      = 1'($urandom_range(1, 0));
            eper     = 3'($urandom_range(7, 0));
            len_load = 6'($urandom_range(63, 0));
            len_en   = 1'($urandom_range(1, 0));
         end
         cyc();
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
